// File: rtl/vga_pkg.sv
// Shared VGA timing types and the standard mode constant sets.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   vga_seg_t   - one axis of a video mode: {active, fp, sync, bp}
//   XGA70_H/V   - 1024x768 @ 70 Hz (the generator's default mode)
//   VGA60_H/V   - 640x480 @ 60 Hz
//   coord_t     - coordinate at the default counter width
//   seg_total() - line or frame length of one axis
package vga_pkg;

  localparam int VGA_CW = 12;

  typedef logic [VGA_CW-1:0] coord_t;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_seg_t;

  localparam vga_seg_t XGA70_H = '{active: 16'd1024, fp: 16'd64, sync: 16'd104, bp: 16'd168};
  localparam vga_seg_t XGA70_V = '{active: 16'd768,  fp: 16'd3,  sync: 16'd4,   bp: 16'd30};
  localparam vga_seg_t VGA60_H = '{active: 16'd640,  fp: 16'd16, sync: 16'd96,  bp: 16'd48};
  localparam vga_seg_t VGA60_V = '{active: 16'd480,  fp: 16'd10, sync: 16'd2,   bp: 16'd33};

  function automatic int seg_total(input vga_seg_t s);
    return int'(s.active) + int'(s.fp) + int'(s.sync) + int'(s.bp);
  endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// One h/v raster counter pair with registered sync/enable/coordinate decode.
// Latency: 1 pixel tick (outputs describe the counter value held before the edge).
// Backpressure: none; pix_en=0 freezes counters and all outputs.
//
// Ports:
//   clk_vga, rst (sync, active-high), pix_en (tick qualifier)
//   hs, vs              - syncs at HS_POL / VS_POL
//   de                  - inside the active area
//   hc_visible/vc_visible - active coordinates, 0 outside the active area
//   line_start/frame_start - one-tick markers at h=0 / (h=0, v=0)
// START is the linear raster position loaded on reset (wraps across lines/frames).
module vga_raster_cnt
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(XGA70_H.active),
  parameter int H_FP     = int'(XGA70_H.fp),
  parameter int H_SYNC   = int'(XGA70_H.sync),
  parameter int H_BP     = int'(XGA70_H.bp),
  parameter int V_ACTIVE = int'(XGA70_V.active),
  parameter int V_FP     = int'(XGA70_V.fp),
  parameter int V_SYNC   = int'(XGA70_V.sync),
  parameter int V_BP     = int'(XGA70_V.bp),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = VGA_CW,
  parameter int START    = 0
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] hc_visible,
  output logic [CW-1:0] vc_visible,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int START_H = START % H_TOTAL;
  localparam int START_V = (START / H_TOTAL) % V_TOTAL;

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_FIRST = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_ACT_FIRST = CW'(V_SYNC + V_BP);
  // Inclusive upper bound: an exclusive bound could equal 2^CW and wrap to 0.
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CW-1:0] H_START     = CW'(START_H);
  localparam logic [CW-1:0] V_START     = CW'(START_V);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          h_act;
  logic          v_act;
  logic          hs_d;
  logic          vs_d;
  logic          de_d;
  logic [CW-1:0] hc_d;
  logic [CW-1:0] vc_d;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_act  = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST);
    v_act  = (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
    hs_d   = (h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
    vs_d   = (v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
    de_d   = h_act && v_act;
    hc_d   = '0;
    vc_d   = '0;
    if (de_d) begin
      hc_d = h_cnt - H_ACT_FIRST;
      vc_d = v_cnt - V_ACT_FIRST;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_cnt       <= H_START;
      v_cnt       <= V_START;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      hc_visible  <= '0;
      vc_visible  <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hs          <= hs_d;
      vs          <= vs_d;
      de          <= de_d;
      hc_visible  <= hc_d;
      vc_visible  <= vc_d;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (h_wrap) begin
        h_cnt <= '0;
        // Lines advance only on the horizontal wrap.
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (sync, display enable, coordinates, markers).
// Latency: 1 pixel tick from counter position to registered outputs.
// Backpressure: none; pix_en=0 holds every output, so pulses last one qualified tick.
//
// Ports:
//   clk_vga, rst (sync, active-high), pix_en (tie 1 when clk_vga is the pixel clock)
//   hs, vs, de, hc_visible, vc_visible, line_start, frame_start
//   px_req, px_x, px_y - only with VGA_TIMING_PREFETCH_EN: same decode as de/hc/vc,
//                        PREFETCH ticks early, to hide framebuffer read latency.
// Optional feature macro: VGA_TIMING_PREFETCH_EN
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(XGA70_H.active),
  parameter int H_FP     = int'(XGA70_H.fp),
  parameter int H_SYNC   = int'(XGA70_H.sync),
  parameter int H_BP     = int'(XGA70_H.bp),
  parameter int V_ACTIVE = int'(XGA70_V.active),
  parameter int V_FP     = int'(XGA70_V.fp),
  parameter int V_SYNC   = int'(XGA70_V.sync),
  parameter int V_BP     = int'(XGA70_V.bp),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = VGA_CW,
  parameter int PREFETCH = 2
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] hc_visible,
  output logic [CW-1:0] vc_visible,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic          px_req,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Counters must hold TOTAL-1; the prefetch lead must land inside sync+back porch
  // so the early request never overlaps the previous line's active span.
  if (H_TOTAL > (1 << CW)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d does not fit in CW=%0d bits", H_TOTAL, CW);
  end
  if (V_TOTAL > (1 << CW)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d does not fit in CW=%0d bits", V_TOTAL, CW);
  end
  if ((PREFETCH < 1) || (PREFETCH >= H_SYNC + H_BP)) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH %0d outside 1..%0d", PREFETCH, H_SYNC + H_BP - 1);
  end

  vga_raster_cnt #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL), .CW (CW), .START (0)
  ) u_main (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .pix_en      (pix_en),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .hc_visible  (hc_visible),
    .vc_visible  (vc_visible),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

`ifdef VGA_TIMING_PREFETCH_EN
  // Second pair starts PREFETCH positions ahead and advances in lock-step,
  // so its decode is the main decode shifted PREFETCH ticks earlier.
  logic pf_hs;
  logic pf_vs;
  logic pf_line_start;
  logic pf_frame_start;
  logic pf_unused;

  vga_raster_cnt #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL), .CW (CW), .START (PREFETCH)
  ) u_prefetch (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .pix_en      (pix_en),
    .hs          (pf_hs),
    .vs          (pf_vs),
    .de          (px_req),
    .hc_visible  (px_x),
    .vc_visible  (px_y),
    .line_start  (pf_line_start),
    .frame_start (pf_frame_start)
  );

  // Sync and marker decode of the lead pair has no consumer.
  assign pf_unused = ^{pf_hs, pf_vs, pf_line_start, pf_frame_start};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster (28x19 ticks per frame).
// A position-based model (tick count -> raster position -> decode) is compared on every cycle.
// Define VGA_TIMING_PREFETCH_EN for both RTL and bench to cover the prefetch port.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 3, H_SY = 4, HB = 5;
  localparam int VA = 10, VF = 2, V_SY = 3, VB = 4;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int CW = 8;
  localparam int PF = 2;
  localparam int HT = HA + HF + H_SY + HB;   // 28
  localparam int VT = VA + VF + V_SY + VB;   // 19
  localparam int FRAME = HT * VT;            // 532

  logic          clk_vga = 1'b0;
  logic          rst     = 1'b1;
  logic          pix_en  = 1'b0;
  logic          hs, vs, de, line_start, frame_start;
  logic [CW-1:0] hc_visible, vc_visible;
`ifdef VGA_TIMING_PREFETCH_EN
  logic          px_req;
  logic [CW-1:0] px_x, px_y;
`endif

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (H_SY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (V_SY), .V_BP (VB),
    .HS_POL (HP), .VS_POL (VP), .CW (CW), .PREFETCH (PF)
  ) dut (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .pix_en      (pix_en),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .hc_visible  (hc_visible),
    .vc_visible  (vc_visible),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_TIMING_PREFETCH_EN
    ,
    .px_req      (px_req),
    .px_x        (px_x),
    .px_y        (px_y)
`endif
  );

  always #5 clk_vga = ~clk_vga;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          ls;
    logic          fs;
  } exp_t;

  // t = qualified ticks since reset; after t ticks the outputs describe position t-1.
  function automatic exp_t model(input int t, input int lead);
    exp_t e;
    int   p, h, v;
    e.hs = !HP; e.vs = !VP; e.de = 1'b0; e.hc = '0; e.vc = '0; e.ls = 1'b0; e.fs = 1'b0;
    if (t > 0) begin
      p = (t - 1 + lead) % FRAME;
      h = p % HT;
      v = p / HT;
      e.hs = (h < H_SY) ? HP : !HP;
      e.vs = (v < V_SY) ? VP : !VP;
      e.de = (h >= H_SY + HB) && (h < H_SY + HB + HA) && (v >= V_SY + VB) && (v < V_SY + VB + VA);
      if (e.de) begin
        e.hc = CW'(h - (H_SY + HB));
        e.vc = CW'(v - (V_SY + VB));
      end
      e.ls = (h == 0);
      e.fs = (p == 0);
    end
    return e;
  endfunction

  int ticks = 0;
  bit chk_en = 1'b0;

  always @(posedge clk_vga) begin
    if (rst) ticks <= 0;
    else if (pix_en) ticks <= ticks + 1;
  end

  always @(negedge clk_vga) begin : compare
    exp_t e;
    if (chk_en) begin
      e = model(ticks, 0);
      cmp("hs", 32'(hs), 32'(e.hs));
      cmp("vs", 32'(vs), 32'(e.vs));
      cmp("de", 32'(de), 32'(e.de));
      cmp("hc_visible", 32'(hc_visible), 32'(e.hc));
      cmp("vc_visible", 32'(vc_visible), 32'(e.vc));
      cmp("line_start", 32'(line_start), 32'(e.ls));
      cmp("frame_start", 32'(frame_start), 32'(e.fs));
`ifdef VGA_TIMING_PREFETCH_EN
      e = model(ticks, PF);
      cmp("px_req", 32'(px_req), 32'(e.de));
      cmp("px_x", 32'(px_x), 32'(e.hc));
      cmp("px_y", 32'(px_y), 32'(e.vc));
`endif
    end
  end

  // Inputs change just after the falling edge, well clear of the rising edge.
  task automatic step(input bit r, input bit en);
    rst    = r;
    pix_en = en;
    @(posedge clk_vga);
    @(negedge clk_vga);
    #1;
  endtask

  initial begin : stim
    exp_t m;
    int fs_first, fs_second, de_cnt, ls_cnt, hs_cnt, first_de, last_hc, last_vc;
    int fs_w;
    bit fs_done;
`ifdef VGA_TIMING_PREFETCH_EN
    int first_req;
    first_req = -1;
`endif

    // Model pins: first active pixel is position (h=9, v=7) = 205, seen after tick 206.
    m = model(206, 0);
    cmp("model_first_de", 32'({m.de, m.hc, m.vc}), 32'({1'b1, 8'd0, 8'd0}));
    m = model(205, 0);
    cmp("model_pre_de", 32'(m.de), 32'(0));
    m = model(473, 0);   // position 472: h=24, v=16 -> last active pixel
    cmp("model_last_px", 32'({m.de, m.hc, m.vc}), 32'({1'b1, 8'd15, 8'd9}));

    // Reset, including a reset edge with pix_en=1.
    step(1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b1);
    cmp("rst_hs", 32'(hs), 32'(0));
    cmp("rst_vs", 32'(vs), 32'(1));
    cmp("rst_de_fs", 32'({de, frame_start, line_start}), 32'(0));

    // Phase A: continuous ticks over two frames.
    fs_first = -1; fs_second = -1; de_cnt = 0; ls_cnt = 0; hs_cnt = 0;
    first_de = -1; last_hc = -1; last_vc = -1;
    for (int n = 1; n <= 2 * FRAME + 40; n++) begin
      step(1'b0, 1'b1);
      if (n == 1) begin
        cmp("first_tick_sync", 32'({hs, vs}), 32'({1'b1, 1'b0}));
        cmp("first_tick_marks", 32'({line_start, frame_start, de}), 32'({1'b1, 1'b1, 1'b0}));
      end
      if (frame_start) begin
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (fs_first >= 0 && fs_second < 0) begin
        de_cnt += int'(de);
        ls_cnt += int'(line_start);
        hs_cnt += int'(hs == HP);
        if (de) begin
          last_hc = int'(hc_visible);
          last_vc = int'(vc_visible);
        end
      end
      if (de && first_de < 0) begin
        first_de = n;
        cmp("first_de_coord", 32'({hc_visible, vc_visible}), 32'(0));
      end
`ifdef VGA_TIMING_PREFETCH_EN
      if (px_req && first_req < 0) begin
        first_req = n;
        cmp("first_req_coord", 32'({px_x, px_y}), 32'(0));
      end
`endif
    end
    cmp("frame_period", 32'(fs_second - fs_first), 32'(FRAME));
    cmp("de_per_frame", 32'(de_cnt), 32'(HA * VA));
    cmp("lines_per_frame", 32'(ls_cnt), 32'(VT));
    cmp("hs_ticks_per_frame", 32'(hs_cnt), 32'(H_SY * VT));
    cmp("first_de_tick", 32'(first_de), 32'(206));
    cmp("last_active_px", 32'({last_hc[7:0], last_vc[7:0]}), 32'({8'd15, 8'd9}));
`ifdef VGA_TIMING_PREFETCH_EN
    cmp("first_req_tick", 32'(first_req), 32'(206 - PF));
`endif

    // Phase B: random pix_en with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 65));
    end

    // Phase C: pix_en 1-0-0 (divide by 3); markers last three clocks.
    step(1'b1, 1'b0);
    fs_w = 0; fs_done = 1'b0;
    for (int n = 0; n < 1700; n++) begin
      step(1'b0, (n % 3) == 0);
      if (!fs_done) begin
        if (frame_start) fs_w++;
        else if (fs_w > 0) fs_done = 1'b1;
      end
    end
    cmp("fs_width_div3", 32'(fs_w), 32'(3));

    // Phase D: reset mid-frame (inside the active area) with pix_en low.
    step(1'b1, 1'b0);
    for (int n = 0; n < 11 * HT + 13; n++) step(1'b0, 1'b1);
    cmp("pre_rst_pos", 32'({de, hc_visible, vc_visible}), 32'({1'b1, 8'd3, 8'd4}));
    step(1'b1, 1'b0);
    cmp("mid_rst_vals", 32'({hs, vs, de, line_start, frame_start, hc_visible, vc_visible}),
        32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}));
    step(1'b0, 1'b1);
    cmp("restart_marks", 32'({hs, vs, line_start, frame_start}), 32'({1'b1, 1'b0, 1'b1, 1'b1}));
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
